// File: rtl/mc_8x8_array_driver.sv
// rtl/mc_8x8_array_driver.sv - request sequencer for the 8x8 dual-memristor compute array
// Turns one-shot row write/read requests into registered word, bit and source line waveforms.
module mc_8x8_array_driver #(
  parameter int WR_PULSE  = 2,
  parameter int RD_SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [2:0] req_row,
  input  logic [7:0] req_data,
  input  logic [7:0] req_mask,
  input  logic [7:0] req_din,
  input  logic [7:0] req_dinb,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [3:0] CWLE,
  output logic [3:0] CWLO,
  output logic [7:0] CBLEN,
  output logic [7:0] CBL,
  output logic [7:0] CSL,
  output logic [7:0] DIN,
  output logic [7:0] DINb,
  input  logic [7:0] DOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_R_SETUP,
    S_R_ARM,
    S_R_EVAL,
    S_R_CLOSE
  } state_t;

  localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_SETTLE - 1);

  state_t     state_q, state_d;
  logic       phase_b_q, phase_b_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;

  logic       f_op_q, f_op_d;
  logic [2:0] f_row_q, f_row_d;
  logic [7:0] f_data_q, f_data_d;
  logic [7:0] f_mask_q, f_mask_d;
  logic [7:0] f_din_q, f_din_d;
  logic [7:0] f_dinb_q, f_dinb_d;

  logic [7:0] dout_q, dout_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  // wl is indexed by row number; it is split into the odd/even word line buses at the pins
  logic [7:0] wl_q, wl_d;
  logic [7:0] cblen_q, cblen_d;
  logic [7:0] cbl_q, cbl_d;
  logic [7:0] csl_q, csl_d;
  logic [7:0] din_q, din_d;
  logic [7:0] dinb_q, dinb_d;
  logic [7:0] row_onehot;

  always_comb begin
    state_d     = state_q;
    phase_b_d   = phase_b_q;
    cnt_d       = cnt_q;
    f_op_d      = f_op_q;
    f_row_d     = f_row_q;
    f_data_d    = f_data_q;
    f_mask_d    = f_mask_q;
    f_din_d     = f_din_q;
    f_dinb_d    = f_dinb_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          f_op_d    = req_op;
          f_row_d   = req_row;
          f_data_d  = req_data;
          f_mask_d  = req_mask;
          f_din_d   = req_din;
          f_dinb_d  = req_dinb;
          phase_b_d = 1'b0;
          state_d   = req_op ? S_R_SETUP : S_W_SETUP;
        end
      end
      S_W_SETUP: begin
        state_d = S_W_PULSE;
        cnt_d   = WR_LAST;
      end
      S_W_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_W_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_W_HOLD: begin
        if (!phase_b_q) begin
          phase_b_d = 1'b1;
          state_d   = S_W_SETUP;
        end else begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 8'h00;
        end
      end
      S_R_SETUP: begin
        state_d = S_R_ARM;
      end
      S_R_ARM: begin
        state_d = S_R_EVAL;
        cnt_d   = RD_LAST;
      end
      S_R_EVAL: begin
        if (cnt_q == 4'd0) begin
          state_d = S_R_CLOSE;
          dout_d  = DOUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_R_CLOSE: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = dout_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Array drives are decoded from the state being entered so every pin is a flop output
  always_comb begin
    row_onehot = 8'd1 << f_row_d;
    wl_d       = 8'h00;
    cblen_d    = 8'h00;
    cbl_d      = 8'h00;
    csl_d      = 8'h00;
    din_d      = 8'h00;
    dinb_d     = 8'h00;
    ready_d    = (state_d == S_IDLE);

    case (state_d)
      S_W_SETUP, S_W_PULSE, S_W_HOLD: begin
        cblen_d = f_mask_d;
        cbl_d   = ~f_data_d;
        csl_d   = phase_b_d ? ~f_data_d : f_data_d;
        if (state_d == S_W_PULSE) begin
          wl_d = row_onehot;
        end
      end
      S_R_SETUP: begin
        csl_d  = 8'hFF;
        din_d  = f_din_d;
        dinb_d = f_dinb_d;
      end
      S_R_ARM: begin
        wl_d   = row_onehot;
        csl_d  = 8'hFF;
        din_d  = f_din_d;
        dinb_d = f_dinb_d;
      end
      S_R_EVAL: begin
        wl_d   = row_onehot;
        din_d  = f_din_d;
        dinb_d = f_dinb_d;
      end
      S_R_CLOSE: begin
        din_d  = f_din_d;
        dinb_d = f_dinb_d;
      end
      default: begin
        wl_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_b_q   <= 1'b0;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      f_op_q      <= 1'b0;
      f_row_q     <= 3'd0;
      f_data_q    <= 8'h00;
      f_mask_q    <= 8'h00;
      f_din_q     <= 8'h00;
      f_dinb_q    <= 8'h00;
      dout_q      <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      wl_q        <= 8'h00;
      cblen_q     <= 8'h00;
      cbl_q       <= 8'h00;
      csl_q       <= 8'h00;
      din_q       <= 8'h00;
      dinb_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_b_q   <= phase_b_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      f_op_q      <= f_op_d;
      f_row_q     <= f_row_d;
      f_data_q    <= f_data_d;
      f_mask_q    <= f_mask_d;
      f_din_q     <= f_din_d;
      f_dinb_q    <= f_dinb_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wl_q        <= wl_d;
      cblen_q     <= cblen_d;
      cbl_q       <= cbl_d;
      csl_q       <= csl_d;
      din_q       <= din_d;
      dinb_q      <= dinb_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign CWLO      = {wl_q[6], wl_q[4], wl_q[2], wl_q[0]};
  assign CWLE      = {wl_q[7], wl_q[5], wl_q[3], wl_q[1]};
  assign CBLEN     = cblen_q;
  assign CBL       = cbl_q;
  assign CSL       = csl_q;
  assign DIN       = din_q;
  assign DINb      = dinb_q;

endmodule

// File: tb/tb_mc_8x8_array_driver.sv
// tb/tb_mc_8x8_array_driver.sv - directed bench for mc_8x8_array_driver with a behavioural array
module tb_mc_8x8_array_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [2:0] req_row = 3'd0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] req_mask = 8'h00;
  logic [7:0] req_din = 8'h00;
  logic [7:0] req_dinb = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [3:0] CWLE, CWLO;
  logic [7:0] CBLEN, CBL, CSL, DIN, DINb;
  logic [7:0] dout_m;
  logic [7:0] wl;

  int n_checks = 0;
  int n_fail = 0;

  mc_8x8_array_driver #(.WR_PULSE(2), .RD_SETTLE(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_row(req_row), .req_data(req_data), .req_mask(req_mask), .req_din(req_din),
    .req_dinb(req_dinb), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .CWLE(CWLE), .CWLO(CWLO),
    .CBLEN(CBLEN), .CBL(CBL), .CSL(CSL), .DIN(DIN), .DINb(DINb), .DOUT(dout_m)
  );

  always #5 clk = ~clk;

  assign wl = {CWLE[3], CWLO[3], CWLE[2], CWLO[2], CWLE[1], CWLO[1], CWLE[0], CWLO[0]};

  // Behavioural macro: CBL!=CSL programs m0, CBL==CSL programs m1, CSL carries the value
  logic [7:0] m0 [8] = '{default: 8'h00};
  logic [7:0] m1 [8] = '{default: 8'h00};

  always @(posedge clk) begin
    for (int r = 0; r < 8; r++) begin
      if (wl[r]) begin
        for (int c = 0; c < 8; c++) begin
          if (CBLEN[c]) begin
            if (CBL[c] != CSL[c]) m0[r][c] <= CSL[c];
            else m1[r][c] <= CSL[c];
          end
        end
      end
    end
  end

  always_comb begin
    dout_m = 8'h00;
    for (int r = 0; r < 8; r++) begin
      if (wl[r] && CSL == 8'h00) dout_m = ~((m0[r] & DIN) | (m1[r] & DINb));
    end
  end

  logic [7:0]  prev_wl = 8'h00;
  logic [23:0] prev_bus = 24'h0;

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (!$onehot0(wl)) begin
        n_fail++;
        $display("FAIL wl_onehot: got %h required at most one bit", wl);
      end
      if (wl != 8'h00 && prev_wl != 8'h00 && prev_bus[7:0] != 8'h00) begin
        n_checks++;
        if ({CBL, CSL, CBLEN} !== prev_bus) begin
          n_fail++;
          $display("FAIL bus_stable_wl_high: got %h required %h", {CBL, CSL, CBLEN}, prev_bus);
        end
      end
    end
    prev_wl  = wl;
    prev_bus = {CBL, CSL, CBLEN};
  end

  logic [7:0] c_wl [40];
  logic [7:0] c_csl [40];
  logic [7:0] c_cbl [40];
  logic [7:0] c_cblen [40];
  logic [7:0] c_din [40];
  logic [7:0] c_dinb [40];
  logic       c_rdy [40];
  int         rsp_cyc;
  logic [7:0] rsp_val;

  task automatic issue(input logic op, input logic [2:0] row, input logic [7:0] data,
                       input logic [7:0] mask, input logic [7:0] din, input logic [7:0] dinb);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_row = row; req_data = data;
    req_mask = mask; req_din = din; req_dinb = dinb;
    rsp_cyc = 0;
    rsp_val = 8'hxx;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      c_wl[k] = wl; c_csl[k] = CSL; c_cbl[k] = CBL; c_cblen[k] = CBLEN;
      c_din[k] = DIN; c_dinb[k] = DINb; c_rdy[k] = req_ready;
      if (rsp_valid) begin
        rsp_cyc = k;
        rsp_val = rsp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({CWLE, CWLO, CBLEN, CBL, CSL, DIN, DINb, rsp_data, rsp_valid} !== 57'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h required 0",
                 {CWLE, CWLO, CBLEN, CBL, CSL, DIN, DINb, rsp_data, rsp_valid});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: got ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_write_row0();
    logic [7:0] exp_wl, exp_csl;
    issue(1'b0, 3'd0, 8'hA5, 8'hFF, 8'h00, 8'h00);
    n_checks++;
    if (rsp_cyc !== 9) begin
      n_fail++;
      $display("FAIL wr0_latency: got %0d required 9", rsp_cyc);
    end
    for (int k = 1; k <= 8; k++) begin
      exp_wl  = (k == 2 || k == 3 || k == 6 || k == 7) ? 8'h01 : 8'h00;
      exp_csl = (k <= 4) ? 8'hA5 : 8'h5A;
      n_checks++;
      if ({c_wl[k], c_cbl[k], c_csl[k], c_cblen[k], c_rdy[k]} !== {exp_wl, 8'h5A, exp_csl, 8'hFF, 1'b0}) begin
        n_fail++;
        $display("FAIL wr0_cycle%0d: got wl=%h cbl=%h csl=%h cblen=%h rdy=%b required %h 5a %h ff 0",
                 k, c_wl[k], c_cbl[k], c_csl[k], c_cblen[k], c_rdy[k], exp_wl, exp_csl);
      end
    end
    n_checks++;
    if ({rsp_val, c_wl[9], c_cbl[9], c_csl[9], c_cblen[9]} !== 40'h0) begin
      n_fail++;
      $display("FAIL wr0_done: got rsp=%h wl=%h cbl=%h csl=%h cblen=%h required all 0",
               rsp_val, c_wl[9], c_cbl[9], c_csl[9], c_cblen[9]);
    end
  endtask

  task automatic test_read_row0();
    logic [7:0] exp_wl, exp_csl;
    issue(1'b1, 3'd0, 8'h00, 8'h00, 8'hFF, 8'h00);
    n_checks++;
    if (rsp_cyc !== 5 || rsp_val !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd0_din: got cyc=%0d data=%h required 5 5a", rsp_cyc, rsp_val);
    end
    for (int k = 1; k <= 4; k++) begin
      exp_wl  = (k == 2 || k == 3) ? 8'h01 : 8'h00;
      exp_csl = (k <= 2) ? 8'hFF : 8'h00;
      n_checks++;
      if ({c_wl[k], c_csl[k], c_cblen[k], c_din[k], c_dinb[k]} !== {exp_wl, exp_csl, 8'h00, 8'hFF, 8'h00}) begin
        n_fail++;
        $display("FAIL rd0_cycle%0d: got wl=%h csl=%h cblen=%h din=%h dinb=%h required %h %h 00 ff 00",
                 k, c_wl[k], c_csl[k], c_cblen[k], c_din[k], c_dinb[k], exp_wl, exp_csl);
      end
    end
    n_checks++;
    if ({c_din[5], c_dinb[5], c_csl[5]} !== 24'h0) begin
      n_fail++;
      $display("FAIL rd0_idle_drives: got %h required 0", {c_din[5], c_dinb[5], c_csl[5]});
    end
    issue(1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'hFF);
    n_checks++;
    if (rsp_cyc !== 5 || rsp_val !== 8'hA5) begin
      n_fail++;
      $display("FAIL rd0_dinb: got cyc=%0d data=%h required 5 a5", rsp_cyc, rsp_val);
    end
  endtask

  task automatic test_mask_row5();
    logic [7:0] exp_wl;
    issue(1'b0, 3'd5, 8'hFF, 8'hFF, 8'h00, 8'h00);
    issue(1'b0, 3'd5, 8'h00, 8'h0F, 8'h00, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      exp_wl = (k == 2 || k == 3 || k == 6 || k == 7) ? 8'h20 : 8'h00;
      n_checks++;
      if ({c_wl[k], c_cblen[k]} !== {exp_wl, 8'h0F}) begin
        n_fail++;
        $display("FAIL mask5_cycle%0d: got wl=%h cblen=%h required %h 0f", k, c_wl[k], c_cblen[k], exp_wl);
      end
    end
    issue(1'b1, 3'd5, 8'h00, 8'h00, 8'hFF, 8'h00);
    n_checks++;
    if (rsp_cyc !== 5 || rsp_val !== 8'h0F) begin
      n_fail++;
      $display("FAIL mask5_read: got cyc=%0d data=%h required 5 0f", rsp_cyc, rsp_val);
    end
  endtask

  task automatic test_back_to_back();
    logic       rv [21];
    logic       rdy [21];
    logic [7:0] rd [21];
    int         n_rsp;
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_row = 3'd2; req_data = 8'h3C; req_mask = 8'hFF;
    req_din = 8'h00; req_dinb = 8'h00;
    n_rsp = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_op = 1'b1; req_data = 8'h00; req_mask = 8'h00; req_din = 8'hFF; req_dinb = 8'h00;
      end
      if (k == 10) req_valid = 1'b0;
      rv[k] = rsp_valid; rdy[k] = req_ready; rd[k] = rsp_data;
      if (rsp_valid) n_rsp++;
    end
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (rdy[k] !== 1'b0 || rv[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_busy_cycle%0d: got ready=%b rsp_valid=%b required 0 0", k, rdy[k], rv[k]);
      end
    end
    n_checks++;
    if ({rv[9], rdy[9], rd[9], rdy[10]} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_handover: got rv=%b rdy=%b data=%h rdy_next=%b required 1 1 00 0",
               rv[9], rdy[9], rd[9], rdy[10]);
    end
    n_checks++;
    if (rv[14] !== 1'b1 || rd[14] !== 8'hC3 || n_rsp !== 2) begin
      n_fail++;
      $display("FAIL b2b_read: got rv=%b data=%h responses=%0d required 1 c3 2", rv[14], rd[14], n_rsp);
    end
  endtask

  task automatic test_reset_mid_write();
    int n_rsp;
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_row = 3'd3; req_data = 8'h81; req_mask = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wl !== 8'h08) begin
      n_fail++;
      $display("FAIL rstmid_pulse: got wl=%h required 08", wl);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({CWLE, CWLO, CBLEN, CBL, CSL, DIN, DINb, rsp_valid} !== 49'h0) begin
      n_fail++;
      $display("FAIL rstmid_drives: got %h required 0", {CWLE, CWLO, CBLEN, CBL, CSL, DIN, DINb, rsp_valid});
    end
    rst = 1'b0;
    n_rsp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    n_checks++;
    if (n_rsp !== 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got responses=%0d ready=%b required 0 1", n_rsp, req_ready);
    end
    issue(1'b0, 3'd3, 8'h81, 8'hFF, 8'h00, 8'h00);
    issue(1'b1, 3'd3, 8'h00, 8'h00, 8'hFF, 8'h00);
    n_checks++;
    if (rsp_cyc !== 5 || rsp_val !== 8'h7E) begin
      n_fail++;
      $display("FAIL rstmid_read_din: got cyc=%0d data=%h required 5 7e", rsp_cyc, rsp_val);
    end
    issue(1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 8'hFF);
    n_checks++;
    if (rsp_cyc !== 5 || rsp_val !== 8'h81) begin
      n_fail++;
      $display("FAIL rstmid_read_dinb: got cyc=%0d data=%h required 5 81", rsp_cyc, rsp_val);
    end
  endtask

  initial begin
    test_reset();
    test_write_row0();
    test_read_row0();
    test_mask_row5();
    test_back_to_back();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
